// File: rtl/bin2bcd_seq_pkg.sv
// ============================================================================
// Module : bin2bcd_seq_pkg
// Brief  : Shared constants and FSM state type for the sequential binary-to-BCD converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bin2bcd_seq_pkg;

  localparam int              BCD_W      = 4;
  localparam logic [BCD_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage : bin2bcd_seq_pkg

`default_nettype wire

// File: rtl/bcd_adj3.sv
// ============================================================================
// Module : bcd_adj3
// Brief  : Combinational double-dabble digit correction: add 3 when the digit is 5 or more.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_adj3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit
);

  // Scratch digits never exceed 9 before correction, so the sum is at most 12.
  assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;

endmodule : bcd_adj3

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Converts {overflow, sum} to packed BCD by shift-add-3, one bit per clock.
//          Leading-zero blanking is built only when BIN2BCD_BLANK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      sum,
  input  logic                  overflow,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS-1:0]     blank
);

  localparam int BIN_W = WIDTH + 1;
  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 2);

  state_t             r_state, w_state_nxt;
  logic [BIN_W-1:0]   r_bin,   w_bin_nxt;
  logic [SCR_W-1:0]   r_scr,   w_scr_nxt;
  logic [SCR_W-1:0]   w_scr_adj;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [SCR_W-1:0]   r_bcd,   w_bcd_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_done,  w_done_nxt;
  logic [DIGITS-1:0]  r_blank, w_blank_nxt;
  logic [DIGITS-1:0]  w_blank_calc;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_adj3 u_adj (
      .i_digit (r_scr[i*BCD_W +: BCD_W]),
      .o_digit (w_scr_adj[i*BCD_W +: BCD_W])
    );
  end

`ifdef BIN2BCD_BLANK_EN
  // Digit 0 is never blanked so a zero result still shows one "0".
  assign w_blank_calc[0] = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_blank
    assign w_blank_calc[i] = ~|r_scr[SCR_W-1:i*BCD_W];
  end
`else
  assign w_blank_calc = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_blank <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_scr   <= w_scr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcd   <= w_bcd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_scr_nxt   = r_scr;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_blank_nxt = r_blank;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_bin_nxt   = {overflow, sum};
          w_scr_nxt   = '0;
          w_cnt_nxt   = CNT_W'(BIN_W);
          w_busy_nxt  = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        {w_scr_nxt, w_bin_nxt} = {w_scr_adj[SCR_W-2:0], r_bin, 1'b0};
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_bcd_nxt   = r_scr;
        w_blank_nxt = w_blank_calc;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bcd   = r_bcd;
  assign busy  = r_busy;
  assign done  = r_done;
  assign blank = r_blank;

endmodule : bin2bcd_seq

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module : tb_bin2bcd_seq
// Brief  : Directed self-checking bench for bin2bcd_seq (blank expectations follow BIN2BCD_BLANK_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  sum;
  logic        overflow;
  logic [11:0] bcd;
  logic        busy;
  logic        done;
  logic [2:0]  blank;

  int n_cmp = 0;
  int n_err = 0;

  bin2bcd_seq #(.WIDTH(6), .DIGITS(3)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sum      (sum),
    .overflow (overflow),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .blank    (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_blank(input int v);
`ifdef BIN2BCD_BLANK_EN
    ref_blank = {(v < 100), (v < 10), 1'b0};
`else
    ref_blank = 3'b000;
    if (v < 0) ref_blank = 3'b111;
`endif
  endfunction

  // Waits (bounded) for done after start has been sampled; returns samples taken.
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 20);
  endtask

  task automatic convert(input string tag, input int v, input bit chk_lat);
    int cyc;
    sum      = 6'(v);
    overflow = v[6];
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (chk_lat) chk({tag, "_lat"}, cyc, 9);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
    chk({tag, "_blank"}, 32'(blank), 32'(ref_blank(v)));
    @(negedge clk);
    chk({tag, "_done1"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int n_done;
    int first_done;
    int second_done;
    int busy_lo;

    rst = 1'b1; start = 1'b0; sum = '0; overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Boundary values
    convert("zero", 0, 1'b1);
    convert("v63", 63, 1'b1);
    convert("v64", 64, 1'b1);
    convert("v127", 127, 1'b1);

    // Exhaustive sweep, one done per start
    for (int v = 0; v < 128; v++) convert($sformatf("ex%0d", v), v, 1'b0);

    // start held high: accepts at sample 0 and 9, both done pulses 9 apart
    sum = 6'd7; overflow = 1'b0; start = 1'b1;
    n_done = 0; first_done = 0; second_done = 0; busy_lo = 0;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (c == 18) start = 1'b0;
      if (done) begin
        n_done++;
        if (n_done == 1) first_done = c;
        if (n_done == 2) second_done = c;
      end
      if (c <= 17 && !busy) busy_lo++;
    end
    chk("hold_ndone", n_done, 2);
    chk("hold_first", first_done, 9);
    chk("hold_gap", second_done - first_done, 9);
    chk("hold_busygap", busy_lo, 1);
    chk("hold_bcd", 32'(bcd), 32'h007);
    chk("hold_blank", 32'(blank), 32'(ref_blank(7)));
    convert("after_hold", 7, 1'b1);

    // Input change mid-conversion is not seen
    sum = 6'd5; overflow = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sum = 6'd42;
    wait_done(cyc);
    chk("midchg_done", 32'(done), 32'd1);
    chk("midchg_bcd", 32'(bcd), 32'h005);

    // Reset aborts a conversion in flight
    @(negedge clk);
    sum = 6'd35; overflow = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_nodone", n_done, 0);
    convert("post_abort", 99, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bin2bcd_seq

`default_nettype wire
